imem_responder: RTL and testbench
=================================

// Module: imem_responder
// PURPOSE
//  Instruction-memory responder for the fetch stage's read port (mem_valid/mem_addr/mem_rdata).
//  Holds the program image and serves the fetch stage's combinational read.
//  Contains a byte-serial boot loader that fills memory after reset, holding the core (hlt) until done.
//  Sits between the UART/host byte source and the core; the fetch stage is its only reader.
// PARAMETERS
//  DEPTH_WORDS  1024          number of 32-bit words; power of two, >=4
//  BASE_ADDR    32'h00000000  byte address of word 0; must be 4-byte aligned
//  FILL_WORD    32'h00000013  returned for out-of-range or halted reads (addi x0,x0,0)
// PORTS
//  clk        in   1   clock, all state on posedge
//  rstn       in   1   synchronous reset, active-low
//  mem_valid  in   1   fetch read request (fetch drives constant 1)
//  mem_addr   in   32  fetch byte address
//  mem_rdata  out  32  instruction word, combinational from mem_addr
//  ld_valid   in   1   loader byte valid
//  ld_data    in   8   loader byte
//  ld_ready   out  1   loader byte accepted when ld_valid&&ld_ready
//  hlt        out  1   core halt; drives fetch hlt
//  boot_done  out  1   1 once image loaded; stays 1 until reset
//  fault      out  1   sticky fault; only with IMEM_FAULT_EN
// BEHAVIOUR
//  - FSM states: LOAD_LEN -> LOAD_DATA -> RUN. Reset (rstn=0 at posedge) forces LOAD_LEN, byte_cnt=0, word_idx=0, len=0.
//  - Reset outputs: hlt=1, ld_ready=1, boot_done=0, fault=0. Memory contents are NOT cleared by reset.
//  - LOAD_LEN: accept 4 bytes little-endian into len (word count). On 4th byte: len==0 -> RUN, else -> LOAD_DATA.
//  - LOAD_DATA: accept bytes little-endian. The 4th byte writes {byte3,byte2,byte1,byte0} to mem[word_idx] on that edge.
//    After the write, word_idx increments; when word_idx+1==len -> RUN on the same edge.
//  - Writes with word_idx>=DEPTH_WORDS are consumed (ld_ready stays 1) and dropped; no wrap-around.
//  - RUN: hlt=0, ld_ready=0, boot_done=1. Further ld_valid is ignored. Only reset leaves RUN.
//  - ld_ready=1 in both LOAD states, so throughput is one byte per cycle. ld_valid=0 cycles stall with no state change.
//  - Read path: idx=(mem_addr-BASE_ADDR)>>2; addr[1:0] are ignored.
//    mem_rdata=mem[idx] if hlt==0 && mem_addr>=BASE_ADDR && idx<DEPTH_WORDS, else FILL_WORD.
//    Zero latency: the fetch stage latches mem_rdata at the same edge that advances the PC.
//  - mem_valid=0 does not change mem_rdata (it is a pure function of addr/hlt).
//  - Reset mid-load: partially written words remain, the loader restarts at LOAD_LEN, and hlt is reasserted.
//  - Arithmetic: len and word_idx are 32-bit unsigned. Comparisons are unsigned. byte_cnt is 2-bit and wraps 3->0 after each word.
// CONFIGURATION
//  IMEM_FAULT_EN defined:
//    - fault port present.
//    - fault sets (sticky) at the edge where mem_valid&&!hlt and the read is out of range.
//    - fault also sets at any dropped load word (word_idx>=DEPTH_WORDS).
//    - fault is cleared only by reset.
//  IMEM_FAULT_EN undefined: fault port and logic absent; all other behaviour identical.
// STRUCTURE
//  - imem_pkg: state encoding localparams (ST_LOAD_LEN, ST_LOAD_DATA, ST_RUN), NOP constant for FILL_WORD default.
//  - Sub-module imem_loader: FSM, byte assembly, len/word_idx counters.
//    Outputs wr_en/wr_idx/wr_data/hlt/boot_done.
//  - The top holds the memory array and the read mux.
// TESTING
//  1. Reset, then send len=2, words 0x00500093,0x00100113 -> hlt=1 throughout, hlt=0 the cycle after byte 12; mem_rdata@0=0x00500093, @4=0x00100113.
//  2. len=0 (bytes 00 00 00 00) -> RUN after 4th byte, boot_done=1, mem_rdata@0 = prior contents.
//  3. Gapped ld_valid (1 byte every 3 cycles) for len=1 -> identical image as back-to-back; ld_ready=1 until RUN.
//  4. DEPTH_WORDS=4, len=6 -> words 4,5 dropped, all 24 bytes accepted; read @0x10 -> FILL_WORD; fault=1 with IMEM_FAULT_EN.
//  5. rstn=0 after 6 data bytes of len=2, then reload len=1 word 0xDEADBEEF -> mem@0=0xDEADBEEF, hlt drops after 8 bytes.
//  6. While hlt=1, read @0 -> FILL_WORD; in RUN, mem_addr=0x2 -> same word as @0 (low bits ignored).

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Loader state encoding and the default fill instruction.
package imem_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_LOAD_LEN  = 2'd0,
        ST_LOAD_DATA = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch read port and loader byte stream of the instruction memory.
// master = fetch stage / host byte source, slave = imem_responder.
interface imem_responder_if;

    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;

    modport master (
        output mem_valid,
        output mem_addr,
        output ld_valid,
        output ld_data,
        input  mem_rdata,
        input  ld_ready
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  ld_valid,
        input  ld_data,
        output mem_rdata,
        output ld_ready
    );

endinterface

// File: rtl/imem_loader.sv
// Byte-serial boot loader: 32-bit LE word count, then LE data words.
// Emits one write strobe per assembled word and halts the core until done.
module imem_loader
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        wr_en,
    output logic [31:0] wr_idx,
    output logic [31:0] wr_data,
    output logic        hlt,
    output logic        boot_done
);

    state_t      state, state_n;
    logic [1:0]  byte_cnt, byte_cnt_n;
    logic [31:0] word_idx, word_idx_n;
    logic [31:0] len, len_n;
    logic [23:0] asm_q, asm_n;
    logic [31:0] word;
    logic        take;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_LOAD_LEN;
            byte_cnt <= 2'd0;
            word_idx <= 32'd0;
            len      <= 32'd0;
            asm_q    <= 24'd0;
        end else begin
            state    <= state_n;
            byte_cnt <= byte_cnt_n;
            word_idx <= word_idx_n;
            len      <= len_n;
            asm_q    <= asm_n;
        end
    end

    assign word = {ld_data, asm_q};
    assign take = ld_valid && ld_ready;

    always_comb begin
        state_n    = state;
        byte_cnt_n = byte_cnt;
        word_idx_n = word_idx;
        len_n      = len;
        asm_n      = asm_q;
        wr_en      = 1'b0;
        wr_idx     = word_idx;
        wr_data    = word;
        ld_ready   = (state != ST_RUN);
        hlt        = (state != ST_RUN);
        boot_done  = (state == ST_RUN);
        if (take) begin
            byte_cnt_n = byte_cnt + 2'd1;
            // Bytes enter at the top so byte0 ends up lowest.
            asm_n      = {ld_data, asm_q[23:8]};
            if (byte_cnt == 2'd3) begin
                unique case (1'b1)
                    (state == ST_LOAD_LEN): begin
                        len_n   = word;
                        state_n = (word == 32'd0) ? ST_RUN
                                                  : ST_LOAD_DATA;
                    end
                    (state == ST_LOAD_DATA): begin
                        wr_en      = 1'b1;
                        word_idx_n = word_idx + 32'd1;
                        if (word_idx + 32'd1 == len)
                            state_n = ST_RUN;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Instruction memory with boot loader and zero-latency fetch read port.
// Optional sticky out-of-range fault output: define IMEM_FAULT_EN.
module imem_responder
    import imem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] FILL_WORD   = NOP
) (
    input  logic                   clk,
    input  logic                   rstn,
    imem_responder_if.slave        bus,
    output logic                   hlt,
    output logic                   boot_done
`ifdef IMEM_FAULT_EN
    ,
    output logic                   fault
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    logic        wr_en;
    logic [31:0] wr_idx;
    logic [31:0] wr_data;
    logic        wr_ok;
    logic        wr_drop;
    logic [31:0] off;
    logic [31:0] rd_idx;
    logic        rd_ok;

    imem_loader u_loader (
        .clk      (clk),
        .rstn     (rstn),
        .ld_valid (bus.ld_valid),
        .ld_data  (bus.ld_data),
        .ld_ready (bus.ld_ready),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .hlt      (hlt),
        .boot_done(boot_done)
    );

    assign wr_ok   = wr_idx < 32'(DEPTH_WORDS);
    assign wr_drop = wr_en && !wr_ok;

    always_ff @(posedge clk) begin
        if (wr_en && wr_ok)
            mem[wr_idx[AW-1:0]] <= wr_data;
    end

    // Byte-lane bits are dropped by the shift.
    assign off    = bus.mem_addr - BASE_ADDR;
    assign rd_idx = off >> 2;
    assign rd_ok  = (bus.mem_addr >= BASE_ADDR)
                 && (rd_idx < 32'(DEPTH_WORDS));

    assign bus.mem_rdata = (!hlt && rd_ok) ? mem[rd_idx[AW-1:0]]
                                           : FILL_WORD;

`ifdef IMEM_FAULT_EN
    always_ff @(posedge clk) begin
        if (!rstn)
            fault <= 1'b0;
        else if ((bus.mem_valid && !hlt && !rd_ok) || wr_drop)
            fault <= 1'b1;
    end
`else
    logic unused_ok;
    assign unused_ok = bus.mem_valid ^ wr_drop;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: boot load, reset, gaps, overflow.
// Two instances: default geometry and a 4-word one at base 0x100.
module tb_imem_responder;

    localparam logic [31:0] NOPW = 32'h0000_0013;

    logic clk = 1'b0;
    logic rstn;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    imem_responder_if bus ();
    imem_responder_if bus4 ();

    logic hlt, boot_done, hlt4, boot_done4;
`ifdef IMEM_FAULT_EN
    logic fault, fault4;
`endif

    imem_responder dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .hlt      (hlt),
        .boot_done(boot_done)
`ifdef IMEM_FAULT_EN
        ,
        .fault    (fault)
`endif
    );

    imem_responder #(
        .DEPTH_WORDS(4),
        .BASE_ADDR  (32'h0000_0100)
    ) dut4 (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus4),
        .hlt      (hlt4),
        .boot_done(boot_done4)
`ifdef IMEM_FAULT_EN
        ,
        .fault    (fault4)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit s, input logic [7:0] b);
        if (s) begin
            bus4.ld_valid = 1'b1;
            bus4.ld_data  = b;
        end else begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = b;
        end
        tick();
        bus.ld_valid  = 1'b0;
        bus4.ld_valid = 1'b0;
    endtask

    task automatic send_word(input bit s, input logic [31:0] w);
        for (int i = 0; i < 4; i++)
            send(s, w[8*i +: 8]);
    endtask

    task automatic rd(input bit s, input logic [31:0] a,
                      input logic [31:0] exp, input string tag);
        @(negedge clk);
        if (s) bus4.mem_addr = a;
        else   bus.mem_addr  = a;
        #1;
        chk(tag, s ? bus4.mem_rdata : bus.mem_rdata, exp);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    logic [31:0] w;

    initial begin
        rstn          = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0;
        bus.ld_valid  = 1'b0;
        bus.ld_data   = 8'h0;
        bus4.mem_valid = 1'b0;
        bus4.mem_addr  = 32'h100;
        bus4.ld_valid  = 1'b0;
        bus4.ld_data   = 8'h0;
        tick();
        tick();
        chk("rst_hlt", 32'(hlt), 32'd1);
        chk("rst_ready", 32'(bus.ld_ready), 32'd1);
        chk("rst_done", 32'(boot_done), 32'd0);
`ifdef IMEM_FAULT_EN
        chk("rst_fault", 32'(fault), 32'd0);
`endif
        rstn = 1'b1;
        rd(0, 32'h0, NOPW, "halt_rd");

        // Two-word boot image, back to back.
        tick();
        send_word(0, 32'd2);
        send_word(0, 32'h0050_0093);
        w = 32'h0010_0113;
        for (int i = 0; i < 3; i++) send(0, w[8*i +: 8]);
        chk("t1_hlt_b11", 32'(hlt), 32'd1);
        send(0, w[31:24]);
        chk("t1_hlt_b12", 32'(hlt), 32'd0);
        chk("t1_done", 32'(boot_done), 32'd1);
        chk("t1_ready", 32'(bus.ld_ready), 32'd0);
        rd(0, 32'h0, 32'h0050_0093, "t1_rd0");
        rd(0, 32'h4, 32'h0010_0113, "t1_rd4");
        rd(0, 32'h2, 32'h0050_0093, "t6_rd2");
        rd(0, 32'h7, 32'h0010_0113, "t6_rd7");
        rd(0, 32'h1000, NOPW, "t1_oob");
        tick();
        send_word(0, 32'hFFFF_FFFF);
        rd(0, 32'h0, 32'h0050_0093, "run_ignore");
`ifdef IMEM_FAULT_EN
        bus.mem_valid = 1'b0;
        do_reset();
        bus.mem_valid = 1'b1;
`else
        do_reset();
`endif

        // Zero-length image: memory keeps prior contents.
        chk("t2_hlt", 32'(hlt), 32'd1);
        for (int i = 0; i < 3; i++) send(0, 8'h00);
        chk("t2_hlt_b3", 32'(hlt), 32'd1);
        send(0, 8'h00);
        chk("t2_done", 32'(boot_done), 32'd1);
        chk("t2_hlt_b4", 32'(hlt), 32'd0);
        rd(0, 32'h0, 32'h0050_0093, "t2_rd0");

        // One byte every third cycle.
        tick();
        do_reset();
        w = 32'hCAFE_F00D;
        for (int i = 0; i < 8; i++) begin
            send(0, (i < 4) ? ((i == 0) ? 8'h01 : 8'h00)
                            : w[8*(i-4) +: 8]);
            if (i < 7) begin
                tick();
                chk("t3_ready_gap", 32'(bus.ld_ready), 32'd1);
                tick();
                chk("t3_hlt_gap", 32'(hlt), 32'd1);
            end
        end
        chk("t3_hlt", 32'(hlt), 32'd0);
        rd(0, 32'h0, 32'hCAFE_F00D, "t3_rd0");
        rd(0, 32'h4, 32'h0010_0113, "t3_rd4");

        // Reset in the middle of a load, then reload.
        tick();
        do_reset();
        send_word(0, 32'd2);
        send_word(0, 32'h1122_3344);
        send(0, 8'h55);
        send(0, 8'h66);
        rstn = 1'b0;
        tick();
        chk("t5_hlt_rst", 32'(hlt), 32'd1);
        rstn = 1'b1;
        send_word(0, 32'd1);
        w = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) send(0, w[8*i +: 8]);
        chk("t5_hlt_b7", 32'(hlt), 32'd1);
        send(0, w[31:24]);
        chk("t5_hlt_b8", 32'(hlt), 32'd0);
        rd(0, 32'h0, 32'hDEAD_BEEF, "t5_rd0");
        rd(0, 32'h4, 32'h0010_0113, "t5_rd4");
`ifdef IMEM_FAULT_EN
        chk("t5_fault", 32'(fault), 32'd0);
`endif

        // Overflow on the 4-word instance.
        tick();
        send_word(1, 32'd6);
        for (int i = 0; i < 5; i++)
            send_word(1, 32'hA000_0000 + 32'(i));
        w = 32'hA000_0005;
        for (int i = 0; i < 3; i++) send(1, w[8*i +: 8]);
        chk("t4_hlt_b23", 32'(hlt4), 32'd1);
        chk("t4_ready_b23", 32'(bus4.ld_ready), 32'd1);
        send(1, w[31:24]);
        chk("t4_hlt_b24", 32'(hlt4), 32'd0);
        chk("t4_done", 32'(boot_done4), 32'd1);
`ifdef IMEM_FAULT_EN
        chk("t4_fault", 32'(fault4), 32'd1);
`endif
        rd(1, 32'h100, 32'hA000_0000, "t4_rd0");
        rd(1, 32'h10C, 32'hA000_0003, "t4_rd3");
        rd(1, 32'h110, NOPW, "t4_rd4_fill");
        rd(1, 32'h0FC, NOPW, "t4_below");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
